// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared constants for the MMIO bridge register window
package mmio_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0000_0FF0;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CYCLES = 2'd2;
    localparam logic [1:0] OFF_HALT   = 2'd3;

    localparam int ST_COUNT_LSB = 0;
    localparam int ST_EMPTY     = 4;
    localparam int ST_FULL      = 5;
    localparam int ST_OVERFLOW  = 8;
    localparam int ST_HALTED    = 16;

endpackage

// File: rtl/mmio_tx_fifo.sv
// rtl/mmio_tx_fifo.sv - synchronous TX FIFO with count, full/empty and sticky overflow
module mmio_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clr_overflow,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             push_ok, pop_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;
    // Head reads as zero when empty so an idle sink never sees stale data.
    assign head     = empty ? '0 : mem_q[rd_ptr_q];

    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (clr_overflow) begin
            overflow_d = 1'b0;
        end
        if (push & ~push_ok) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mmio_bridge.sv
// rtl/mmio_bridge.sv - core/memory pass-through with a 16-byte MMIO window
// holding a TX FIFO, a cycle counter and a halt register.
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] core_address,
    input  logic [31:0] core_data_out,
    input  logic        core_write_enable,
    output logic [31:0] core_data_in,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_write_enable,
    input  logic [31:0] mem_data_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halted
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          hit;
    logic [1:0]    off;
    logic          reg_wr;
    logic [31:0]   cycles_q, cycles_d;
    logic          halted_q, halted_d;
    logic [31:0]   reg_rdata;
    logic [31:0]   status;
    logic [CW-1:0] fifo_count;
    logic [4:0]    count5;
    logic          fifo_full, fifo_empty, fifo_overflow;
    logic [7:0]    fifo_head;
    logic          unused_addr_lsbs;

    assign hit              = (core_address[31:4] == MMIO_BASE[31:4]);
    assign off              = core_address[3:2];
    assign unused_addr_lsbs = ^core_address[1:0];
    assign reg_wr           = core_write_enable & hit & ~halted_q;

    assign mem_address      = core_address;
    assign mem_data_in      = core_data_out;
    assign mem_write_enable = core_write_enable & ~hit & ~halted_q & ~reset;

    assign tx_valid = ~fifo_empty;
    assign tx_data  = fifo_head;
    assign halted   = halted_q;

    mmio_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (reg_wr && (off == OFF_TXDATA)),
        .push_data    (core_data_out[7:0]),
        .pop          (tx_valid & tx_ready),
        .clr_overflow (reg_wr && (off == OFF_STATUS)),
        .head         (fifo_head),
        .count        (fifo_count),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .overflow     (fifo_overflow)
    );

    assign count5 = 5'(fifo_count);

    always_comb begin
        status                          = '0;
        status[ST_COUNT_LSB +: 4]       = count5[3:0];
        status[ST_EMPTY]                = fifo_empty;
        status[ST_FULL]                 = fifo_full;
        status[ST_OVERFLOW]             = fifo_overflow;
        status[ST_HALTED]               = halted_q;
    end

    always_comb begin
        reg_rdata = '0;
        case (off)
            OFF_TXDATA: reg_rdata = {24'b0, fifo_head};
            OFF_STATUS: reg_rdata = status;
            OFF_CYCLES: reg_rdata = cycles_q;
            default:    reg_rdata = {31'b0, halted_q};
        endcase
    end

    assign core_data_in = hit ? reg_rdata : mem_data_out;

    // A CYCLES write wins over the increment in the same cycle.
    always_comb begin
        cycles_d = cycles_q;
        if (reg_wr && (off == OFF_CYCLES)) begin
            cycles_d = core_data_out;
        end else if (!halted_q) begin
            cycles_d = cycles_q + 32'd1;
        end
        halted_d = halted_q | (reg_wr && (off == OFF_HALT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycles_q <= '0;
            halted_q <= 1'b0;
        end else begin
            cycles_q <= cycles_d;
            halted_q <= halted_d;
        end
    end

endmodule

// File: tb/tb_mmio_bridge.sv
// tb/tb_mmio_bridge.sv - directed self-checking bench for mmio_bridge
module tb_mmio_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] core_address;
    logic [31:0] core_data_out;
    logic        core_write_enable;
    logic [31:0] core_data_in;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_write_enable;
    logic [31:0] mem_data_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halted;

    logic [31:0] mem_model [1024];
    logic [31:0] rd;
    int          errors = 0;
    int          checks = 0;

    localparam logic [31:0] A_TX  = 32'h0000_0FF0;
    localparam logic [31:0] A_ST  = 32'h0000_0FF4;
    localparam logic [31:0] A_CY  = 32'h0000_0FF8;
    localparam logic [31:0] A_HLT = 32'h0000_0FFC;

    always #5 clk = ~clk;

    mmio_bridge dut (
        .clk               (clk),
        .reset             (reset),
        .core_address      (core_address),
        .core_data_out     (core_data_out),
        .core_write_enable (core_write_enable),
        .core_data_in      (core_data_in),
        .mem_address       (mem_address),
        .mem_data_in       (mem_data_in),
        .mem_write_enable  (mem_write_enable),
        .mem_data_out      (mem_data_out),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .halted            (halted)
    );

    always @(posedge clk) begin
        if (mem_write_enable) mem_model[mem_address[11:2]] <= mem_data_in;
    end
    assign mem_data_out = mem_model[mem_address[11:2]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        core_address      = addr;
        core_data_out     = data;
        core_write_enable = 1'b1;
        tick();
        core_write_enable = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data);
        core_address      = addr;
        core_write_enable = 1'b0;
        #1;
        data = core_data_in;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_model[i] = '0;
        reset             = 1'b1;
        core_address      = 32'h0000_0100;
        core_data_out     = 32'hCAFE_F00D;
        core_write_enable = 1'b1;
        tx_ready          = 1'b0;
        #1;
        check("mem_we_forced_low_in_reset", {31'b0, mem_write_enable}, 32'd0);
        tick();
        tick();
        core_write_enable = 1'b0;
        reset             = 1'b0;

        check("reset_tx_valid", {31'b0, tx_valid}, 32'd0);
        check("reset_tx_data", {24'b0, tx_data}, 32'd0);
        check("reset_halted", {31'b0, halted}, 32'd0);
        do_read(A_ST, rd);
        check("reset_status", rd, 32'h0000_0010);
        do_read(A_CY, rd);
        check("reset_cycles", rd, 32'd0);
        repeat (10) tick();
        do_read(A_CY, rd);
        check("cycles_after_10", rd, 32'd10);

        do_write(A_CY, 32'hFFFF_FFFE);
        do_read(A_CY, rd);
        check("cycles_loaded", rd, 32'hFFFF_FFFE);
        tick();
        do_read(A_CY, rd);
        check("cycles_ff", rd, 32'hFFFF_FFFF);
        tick();
        do_read(A_CY, rd);
        check("cycles_wrap", rd, 32'h0000_0000);

        // Pass-through
        core_address      = 32'h0000_0800;
        core_data_out     = 32'h1234_5678;
        core_write_enable = 1'b1;
        #1;
        check("pt_mem_we", {31'b0, mem_write_enable}, 32'd1);
        check("pt_mem_addr", mem_address, 32'h0000_0800);
        check("pt_mem_wdata", mem_data_in, 32'h1234_5678);
        tick();
        core_write_enable = 1'b0;
        do_read(32'h0000_0800, rd);
        check("pt_readback", rd, 32'h1234_5678);
        do_read(32'h0000_0FF6, rd);
        check("status_lsbs_ignored", rd, 32'h0000_0010);
        do_read(32'h0000_1FF4, rd);
        check("outside_window_bit12", rd, 32'h0000_0000);

        // MMIO write does not reach memory
        core_address      = A_TX;
        core_data_out     = 32'h0000_0041;
        core_write_enable = 1'b1;
        #1;
        check("mmio_no_mem_we", {31'b0, mem_write_enable}, 32'd0);
        tick();
        core_write_enable = 1'b0;
        for (int i = 1; i < 9; i++) do_write(A_TX, 32'h41 + i);
        do_read(A_ST, rd);
        check("fill_status", rd, 32'h0000_0128);
        do_read(A_TX, rd);
        check("fill_txdata_read", rd, 32'h0000_0041);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_valid", {31'b0, tx_valid}, 32'd1);
            check("drain_data", {24'b0, tx_data}, 32'h41 + i);
            tick();
        end
        check("drain_empty_valid", {31'b0, tx_valid}, 32'd0);
        do_read(A_ST, rd);
        check("drain_status_ovf", rd, 32'h0000_0110);
        do_write(A_ST, 32'd0);
        do_read(A_ST, rd);
        check("ovf_cleared", rd, 32'h0000_0010);

        // Simultaneous push/pop at full
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) do_write(A_TX, 32'h50 + i);
        do_read(A_ST, rd);
        check("full_status", rd, 32'h0000_0028);
        tx_ready = 1'b1;
        do_write(A_TX, 32'h0000_005A);
        tx_ready = 1'b0;
        do_read(A_ST, rd);
        check("pushpop_full_status", rd, 32'h0000_0028);
        check("pushpop_head", {24'b0, tx_data}, 32'h51);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("pp_drain_data", {24'b0, tx_data}, (i == 7) ? 32'h5A : 32'h51 + i);
            tick();
        end
        check("pp_drain_empty", {31'b0, tx_valid}, 32'd0);

        // Halt
        tx_ready = 1'b0;
        do_write(A_TX, 32'h61);
        do_write(A_TX, 32'h62);
        do_write(A_CY, 32'd100);
        do_write(A_HLT, 32'd0);
        check("halted_set", {31'b0, halted}, 32'd1);
        do_read(A_HLT, rd);
        check("halt_read", rd, 32'd1);
        core_address      = 32'h0000_0804;
        core_data_out     = 32'h0000_DEAD;
        core_write_enable = 1'b1;
        #1;
        check("halt_mem_we_blocked", {31'b0, mem_write_enable}, 32'd0);
        tick();
        core_write_enable = 1'b0;
        do_write(A_TX, 32'h33);
        do_write(A_CY, 32'h0000_0500);
        repeat (3) tick();
        do_read(32'h0000_0804, rd);
        check("halt_mem_unchanged", rd, 32'd0);
        do_read(A_ST, rd);
        check("halt_status", rd, 32'h0001_0002);
        do_read(A_CY, rd);
        check("halt_cycles_frozen", rd, 32'd101);
        tx_ready = 1'b1;
        check("halt_drain0", {24'b0, tx_data}, 32'h61);
        tick();
        check("halt_drain1", {24'b0, tx_data}, 32'h62);
        tick();
        check("halt_drain_empty", {31'b0, tx_valid}, 32'd0);
        tx_ready = 1'b0;

        // Reset mid-operation
        pulse_reset();
        check("reset_clears_halt", {31'b0, halted}, 32'd0);
        for (int i = 0; i < 9; i++) do_write(A_TX, 32'h70 + i);
        tx_ready = 1'b1;
        repeat (5) tick();
        tx_ready = 1'b0;
        do_read(A_ST, rd);
        check("pre_reset_status", rd, 32'h0000_0103);
        pulse_reset();
        check("mid_reset_tx_valid", {31'b0, tx_valid}, 32'd0);
        do_read(A_ST, rd);
        check("mid_reset_status", rd, 32'h0000_0010);
        do_read(A_CY, rd);
        check("mid_reset_cycles", rd, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Sits between the core memory port and the unified memory.
- Decodes a 16-byte MMIO window at the top of the 4 KiB address space and passes every other access through to memory unchanged.
- Provides an 8-entry byte TX FIFO drained by a valid/ready sink, a free-running cycle counter, and a halt register that freezes the system.
- Writing the halt register replaces address-matching halt detection in benches.

Parameters:
- MMIO_BASE, 32'h00000FF0, base of 16-byte register window (word aligned, 16-byte aligned).
- FIFO_DEPTH, 8, TX FIFO entries (power of two, 2..16).

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- core_address  in  32  byte address from core
- core_data_out  in  32  write data from core
- core_write_enable  in  1  core write strobe
- core_data_in  out  32  read data to core
- mem_address  out  32  address to memory
- mem_data_in  out  32  write data to memory
- mem_write_enable  out  1  memory write strobe
- mem_data_out  in  32  read data from memory
- tx_data  out  8  FIFO head byte
- tx_valid  out  1  FIFO non-empty
- tx_ready  in  1  sink accepts head byte
- halted  out  1  halt register state

Behaviour:
- Decode: hit = (core_address[31:4] == MMIO_BASE[31:4]). Offset = core_address[3:2]. Bits [1:0] are ignored.
- Pass-through:
  - mem_address = core_address and mem_data_in = core_data_out, always.
  - mem_write_enable = core_write_enable & ~hit & ~halted.
- Read mux (combinational, same cycle): core_data_in = hit ? reg_rdata : mem_data_out.
- Register map:
  - 0x0 TXDATA: write pushes core_data_out[7:0]. Read returns {24'b0, head byte}, or 0 if empty.
  - 0x4 STATUS: read {15'b0, halted, 7'b0, overflow, 2'b0, full, empty, count[3:0]}. Any write clears overflow.
  - 0x8 CYCLES: read the 32-bit counter. A write loads core_data_out.
  - 0xC HALT: a write of any value sets halted. Read returns {31'b0, halted}.
- All register updates occur on the rising clk edge where core_write_enable & hit & ~halted.
- FIFO:
  - push = write to TXDATA; pop = tx_valid & tx_ready.
  - Push and pop in the same cycle: count unchanged, both take effect; also legal when full.
  - Push while full without pop: data dropped, overflow <= 1 (sticky).
  - Pop while empty is impossible because tx_valid = 0.
  - tx_data is the head entry, stable while tx_valid & ~tx_ready.
  - Pointers are log2(FIFO_DEPTH) bits and wrap. count ranges 0..FIFO_DEPTH.
- CYCLES counter:
  - Increments by 1 every cycle while ~halted; wraps 0xFFFFFFFF -> 0.
  - A write has priority over the increment in that cycle.
- Halt:
  - halted is set one edge after the HALT write and stays set until reset.
  - While halted: memory writes are blocked, all MMIO writes are ignored, and the counter freezes.
  - Reads still work. FIFO draining continues, so the sink can flush the remaining bytes.
- Reset values (the cycle after reset is sampled high):
  - halted = 0, overflow = 0, counter = 0, FIFO empty (tx_valid = 0, tx_data = 0).
  - A reset mid-operation discards FIFO contents.
  - Combinational outputs follow their inputs during reset, but mem_write_enable is additionally forced to 0 while reset = 1.

Decomposition:
- Shared package mmio_pkg holds:
  - offset constants OFF_TXDATA = 2'd0, OFF_STATUS = 2'd1, OFF_CYCLES = 2'd2, OFF_HALT = 2'd3;
  - STATUS bit positions;
  - default MMIO_BASE.
- One natural sub-module, mmio_tx_fifo: synchronous FIFO with push/pop, count, full, empty and overflow, parameterized by depth and width.
- Decode, register file and read mux stay in mmio_bridge.

Test Plan:
- Pass-through: write 0x12345678 to 0x800, read 0x800 -> mem_write_enable = 1 on the write, core_data_in = 0x12345678, FIFO untouched.
- FIFO fill/drain: tx_ready = 0, push 0x41..0x49 (9 bytes) -> count = 8, full = 1, overflow = 1, 0x49 dropped. Raise tx_ready -> 0x41..0x48 emitted in order, one per cycle, then empty = 1.
- Simultaneous push/pop at full: with count = 8 and tx_ready = 1, push 0x5A -> count stays 8, no overflow, 0x5A emitted last.
- Counter: release reset, read CYCLES after 10 edges -> 10. Write 0xFFFFFFFE -> reads 0xFFFFFFFF then 0x00000000 on successive cycles.
- Halt: write HALT, then write memory 0x804 and TXDATA 0x33 -> halted = 1, mem_write_enable = 0, count unchanged, CYCLES frozen, STATUS bit 16 = 1. Pre-halt FIFO bytes still drain.
- Reset mid-operation: 3 bytes queued plus overflow set, pulse reset for one edge -> tx_valid = 0, STATUS = 0x00000010, CYCLES = 0.
